// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, default bit timing and the
// parity rule used by both the transmitter and the receiver.
package uart_pkg;

    localparam int UART_CLKS_PER_BIT = 14;

    localparam logic PARITY_EVEN = 1'b0;
    localparam logic PARITY_ODD  = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_PARITY    = 3'd3,
        ST_STOP      = 3'd4,
        ST_WAIT_HIGH = 3'd5
    } rx_state_e;

    function automatic logic parity_bit(input logic [7:0] data, input logic ptype);
        return (ptype == PARITY_ODD) ? ~^data : ^data;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the serial line; resets to the idle (high) level so
// a reset never looks like a start bit.
module uart_rx_sync (
    input  logic clk_3125,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_3125 or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start, 8 data bits MSB first, parity, stop. Mid-bit sampling
// driven by a down-counter that reloads at each sample point.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | line high, waiting for rx_s low
// START     | counting to the start-bit centre; high there means glitch
// DATA      | sampling 8 data bits one bit period apart
// PARITY    | sampling the parity bit and checking it
// STOP      | sampling the stop bit, publishing the frame
// WAIT_HIGH | stop bit was low; hold off until the line returns high
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int SAMPLE_POINT = CLKS_PER_BIT / 2
) (
    input  logic       clk_3125,
    input  logic       rst_n,
    input  logic       rx,
    input  logic       parity_type,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_parity_err,
    output logic       rx_frame_err,
    output logic       rx_busy
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] BIT_RELOAD    = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] SAMPLE_RELOAD = CNT_W'(SAMPLE_POINT - 1);

    logic rx_s;

    uart_rx_sync u_sync (
        .clk_3125 (clk_3125),
        .rst_n    (rst_n),
        .d        (rx),
        .q        (rx_s)
    );

    rx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       sh_q, sh_d;
    logic             ptype_q, ptype_d;
    logic             perr_q, perr_d;
    logic [7:0]       rx_data_q, rx_data_d;
    logic             rx_valid_q, rx_valid_d;
    logic             rx_parity_err_q, rx_parity_err_d;
    logic             rx_frame_err_q, rx_frame_err_d;
    logic             tick;

    assign tick = (cnt_q == '0);

    always_ff @(posedge clk_3125 or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            cnt_q           <= '0;
            idx_q           <= '0;
            sh_q            <= '0;
            ptype_q         <= PARITY_EVEN;
            perr_q          <= 1'b0;
            rx_data_q       <= '0;
            rx_valid_q      <= 1'b0;
            rx_parity_err_q <= 1'b0;
            rx_frame_err_q  <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            idx_q           <= idx_d;
            sh_q            <= sh_d;
            ptype_q         <= ptype_d;
            perr_q          <= perr_d;
            rx_data_q       <= rx_data_d;
            rx_valid_q      <= rx_valid_d;
            rx_parity_err_q <= rx_parity_err_d;
            rx_frame_err_q  <= rx_frame_err_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        idx_d           = idx_q;
        sh_d            = sh_q;
        ptype_d         = ptype_q;
        perr_d          = perr_q;
        rx_data_d       = rx_data_q;
        rx_valid_d      = 1'b0;
        rx_parity_err_d = rx_parity_err_q;
        rx_frame_err_d  = rx_frame_err_q;

        case (state_q)
            ST_IDLE: begin
                if (!rx_s) begin
                    state_d = ST_START;
                    cnt_d   = SAMPLE_RELOAD;
                    idx_d   = '0;
                    ptype_d = parity_type;
                end
            end
            ST_START: begin
                if (tick) begin
                    state_d = rx_s ? ST_IDLE : ST_DATA;
                    cnt_d   = BIT_RELOAD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_DATA: begin
                if (tick) begin
                    sh_d  = {sh_q[6:0], rx_s};
                    cnt_d = BIT_RELOAD;
                    if (idx_q == 3'd7) begin
                        state_d = ST_PARITY;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_PARITY: begin
                if (tick) begin
                    perr_d  = (rx_s != parity_bit(sh_q, ptype_q));
                    cnt_d   = BIT_RELOAD;
                    state_d = ST_STOP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_STOP: begin
                if (tick) begin
                    // Data is published even on error so software can inspect it.
                    rx_valid_d      = 1'b1;
                    rx_data_d       = sh_q;
                    rx_parity_err_d = perr_q;
                    rx_frame_err_d  = !rx_s;
                    state_d         = rx_s ? ST_IDLE : ST_WAIT_HIGH;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_WAIT_HIGH: begin
                if (rx_s) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign rx_data       = rx_data_q;
    assign rx_valid      = rx_valid_q;
    assign rx_parity_err = rx_parity_err_q;
    assign rx_frame_err  = rx_frame_err_q;
    assign rx_busy       = (state_q != ST_IDLE);

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 14, sets the clk_3125 cycles per serial bit and matches the uart_tx bit period.
REQ-002 Parameter SAMPLE_POINT, default CLKS_PER_BIT/2 (7), sets the cycle offset within a bit at which rx is sampled.
REQ-003 Port clk_3125, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-004 Port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 Port rx, input, 1 bit: asynchronous serial line, idle high.
REQ-006 Port parity_type, input, 1 bit: 0 = even parity (bit = ^data); 1 = odd parity (bit = ~^data).
REQ-007 Port rx_data, output, 8 bits: last received byte, held between frames.
REQ-008 Port rx_valid, output, 1 bit: one-cycle pulse when a frame completes.
REQ-009 Port rx_parity_err, output, 1 bit: parity mismatch on the last frame; valid with rx_valid and held until the next rx_valid.
REQ-010 Port rx_frame_err, output, 1 bit: stop bit sampled low on the last frame; valid with rx_valid and held until the next rx_valid.
REQ-011 Port rx_busy, output, 1 bit: high whenever the FSM is not in IDLE.

Function
REQ-012 Frame format SHALL be: start(0), 8 data bits MSB first, parity bit, stop(1), giving 11 bits.
REQ-013 rx SHALL pass through a 2-flop synchronizer; that synchronized copy (rx_s) SHALL be the only rx signal used by the FSM, which adds 2 cycles of latency.
REQ-014 The FSM SHALL have the states IDLE, START, DATA, PARITY, STOP and WAIT_HIGH.
REQ-015 In IDLE, rx_s==0 SHALL move to START, clear the bit counter and latch parity_type.
REQ-016 In START, the block SHALL sample rx_s at SAMPLE_POINT cycles after entry: 0 moves to DATA; 1 is a glitch and returns to IDLE with no output activity.
REQ-017 In DATA, the block SHALL sample every CLKS_PER_BIT cycles after the start-bit sample and shift into a register as {sh[6:0], rx_s}; after the 8th sample it SHALL move to PARITY.
REQ-018 In PARITY, the block SHALL sample one bit period later and compare against the expected parity computed from the shift register and the latched parity_type.
REQ-019 In STOP, the block SHALL sample one bit period later: 1 returns to IDLE immediately (mid-stop bit); 0 sets frame_err and moves to WAIT_HIGH.
REQ-020 WAIT_HIGH SHALL remain until rx_s==1, then go to IDLE, so no new start is detected on a held-low line or break.
REQ-021 On the cycle after the stop sample, rx_valid SHALL pulse for 1 cycle, and rx_data, rx_parity_err and rx_frame_err SHALL update together.
REQ-022 rx_data SHALL be updated even when an error flag is set.
REQ-023 The bit-cycle counter SHALL be wide enough for CLKS_PER_BIT-1, and the bit index SHALL be 3 bits; neither may wrap inside a frame.
REQ-024 Back-to-back frames SHALL be accepted: a start edge arriving directly after a good stop bit is detected with no lost cycles.
REQ-025 parity_type changes mid-frame SHALL have no effect on the frame in progress.

Reset
REQ-026 While rst_n==0: state=IDLE, counters=0, shift register=0, both synchronizer flops=1, rx_data=8'h00, and rx_valid, rx_parity_err, rx_frame_err and rx_busy=0.
REQ-027 Reset asserted mid-frame SHALL abort the frame with no rx_valid; after release the block SHALL wait for a fresh start bit.

Structure
REQ-028 Package uart_pkg SHALL hold the state enum, the CLKS_PER_BIT default, the parity encoding constants, and a parity function shared with the transmitter.
REQ-029 The synchronizer SHALL be a sub-module, uart_rx_sync (2 flops, reset value 1); all other logic is flat in uart_rx.

Verification
REQ-030 Even parity: parity_type=0, frame 0xA5 with parity bit 0 and stop 1, 14 cycles per bit -> rx_valid pulses once, rx_data=8'hA5, both error flags 0.
REQ-031 Odd parity: parity_type=1, frame 0x3C with parity bit 0 -> rx_parity_err=1, rx_data=8'h3C, rx_frame_err=0.
REQ-032 Glitch: rx low for 3 cycles then high -> no rx_valid, and rx_busy returns low within SAMPLE_POINT+3 cycles.
REQ-033 Bad stop: frame 0x81 with stop bit 0, then line held low 40 cycles then high -> rx_frame_err=1, a single rx_valid, and no second frame detected.
REQ-034 Loopback: uart_tx drives rx with 0x00 then 0xFF back-to-back, with parity_type 0 and 1 -> two rx_valid pulses, correct bytes, no errors.
REQ-035 Reset mid-frame: rst_n pulsed low during data bit 4 of 0x5A -> no rx_valid, outputs at reset values, and the next complete frame 0x5A is received correctly.
